// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer of the 8-bit bus machine.
// Contents:
//   - opcode constants (upper nibble of the instruction register)
//   - sequencer mode and decoded state encodings
//   - the control word struct and its all-inactive default
//   - decode_state(): maps sequencer mode + ring position onto a single state
package ctrl_pkg;

    localparam int unsigned TStates = 6;

    localparam logic [3:0] OpLda = 4'b0000;
    localparam logic [3:0] OpAdd = 4'b0001;
    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpSta = 4'b0011;
    localparam logic [3:0] OpJmp = 4'b0100;
    localparam logic [3:0] OpOut = 4'b1110;
    localparam logic [3:0] OpHlt = 4'b1111;

    // Registered sequencer mode; the T-state position lives in the ring counter.
    typedef enum logic [1:0] {
        ModeClr,
        ModeRun,
        ModeHalt
    } mode_e;

    typedef enum logic [2:0] {
        StClr,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalt
    } state_e;

    typedef struct packed {
        logic pc_clr;
        logic pc_inc;
        logic enable_pc;
        logic load_pc;
        logic load_mar_bar;
        logic ram_read_bar;
        logic ram_write_bar;
        logic enable_ram_bar;
        logic load_ir_bar;
        logic enable_ir_bar;
        logic load_a_bar;
        logic enable_a_bar;
        logic load_b_bar;
        logic add_sub_bar;
        logic enable_alu_bar;
        logic load_out_bar;
        logic halt;
    } ctrl_t;

    localparam ctrl_t CtrlIdle = '{
        pc_clr:         1'b0,
        pc_inc:         1'b0,
        enable_pc:      1'b0,
        load_pc:        1'b0,
        load_mar_bar:   1'b1,
        ram_read_bar:   1'b1,
        ram_write_bar:  1'b1,
        enable_ram_bar: 1'b1,
        load_ir_bar:    1'b1,
        enable_ir_bar:  1'b1,
        load_a_bar:     1'b1,
        enable_a_bar:   1'b1,
        load_b_bar:     1'b1,
        add_sub_bar:    1'b1,
        enable_alu_bar: 1'b1,
        load_out_bar:   1'b1,
        halt:           1'b0
    };

    function automatic state_e decode_state(input mode_e mode,
                                            input logic [TStates-1:0] ring);
        state_e st;
        st = StClr;
        unique case (mode)
            ModeClr:  st = StClr;
            ModeHalt: st = StHalt;
            ModeRun: begin
                unique case (ring)
                    6'b000001: st = StT1;
                    6'b000010: st = StT2;
                    6'b000100: st = StT3;
                    6'b001000: st = StT4;
                    6'b010000: st = StT5;
                    6'b100000: st = StT6;
                    default:   st = StClr;
                endcase
            end
            default: st = StClr;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/control_sequencer_ring_counter.sv
// One-hot T-state ring counter.
// Ports:
//   clk     - system clock
//   clr_bar - asynchronous active-low reset, clears the ring to all zeros
//   run     - high while instructions execute; low in CLR and HALT
//   ring    - one-hot T1..T6 position (bit0 = T1), all zeros while not running
module ring_counter #(
    parameter int unsigned Width = 6
) (
    input  logic             clk,
    input  logic             clr_bar,
    input  logic             run,
    output logic [Width-1:0] ring
);

    logic [Width-1:0] ring_q, ring_d;

    // While idle the ring is pre-armed at T1 so the first running cycle is T1.
    always_comb begin
        ring_d = {{(Width-1){1'b0}}, 1'b1};
        if (run) begin
            ring_d = {ring_q[Width-2:0], ring_q[Width-1]};
        end
    end

    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar) begin
            ring_q <= '0;
        end else begin
            ring_q <= ring_d;
        end
    end

    // The pre-armed value must not be visible in CLR or HALT.
    assign ring = run ? ring_q : '0;

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: fetches and executes instructions for the 8-bit bus machine by
// producing every load/enable/clear/increment strobe from the current T-state and opcode.
// Ports:
//   clk, clr_bar              - clock and asynchronous active-low reset (forces CLR)
//   opcode[3:0]               - instruction register upper nibble, used in T4..T6 only
//   pc_clr, pc_inc, enable_pc, load_pc          - program counter strobes (active high)
//   load_mar_bar                                - MAR load (active low)
//   ram_read_bar, ram_write_bar, enable_ram_bar - RAM strobes (active low)
//   load_ir_bar, enable_ir_bar                  - instruction register strobes (active low)
//   load_a_bar, enable_a_bar, load_b_bar        - A/B register strobes (active low)
//   add_sub_bar, enable_alu_bar                 - ALU mode (1 = add) and drive (active low)
//   load_out_bar                                - output register load (active low)
//   halt                                        - high once HLT has executed
//   t_state[5:0]                                - one-hot T1..T6, zero in CLR and HALT
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned T_STATES = 6  // fixed at 6 in this version
) (
    input  logic                clk,
    input  logic                clr_bar,
    input  logic [3:0]          opcode,
    output logic                pc_clr,
    output logic                pc_inc,
    output logic                enable_pc,
    output logic                load_pc,
    output logic                load_mar_bar,
    output logic                ram_read_bar,
    output logic                ram_write_bar,
    output logic                enable_ram_bar,
    output logic                load_ir_bar,
    output logic                enable_ir_bar,
    output logic                load_a_bar,
    output logic                enable_a_bar,
    output logic                load_b_bar,
    output logic                add_sub_bar,
    output logic                enable_alu_bar,
    output logic                load_out_bar,
    output logic                halt,
    output logic [T_STATES-1:0] t_state
);

    mode_e               mode_q, mode_d;
    logic                run;
    logic [T_STATES-1:0] ring;
    state_e              state;
    ctrl_t               ctrl;

    assign run = (mode_q == ModeRun);

    ring_counter #(
        .Width(T_STATES)
    ) u_ring_counter (
        .clk    (clk),
        .clr_bar(clr_bar),
        .run    (run),
        .ring   (ring)
    );

    assign state   = decode_state(mode_q, ring);
    assign t_state = ring;

    always_comb begin
        mode_d = mode_q;
        unique case (mode_q)
            ModeClr:  mode_d = ModeRun;
            ModeRun: begin
                if (state == StT4 && opcode == OpHlt) begin
                    mode_d = ModeHalt;
                end
            end
            ModeHalt: mode_d = ModeHalt;  // only reset leaves HALT
            default:  mode_d = ModeClr;
        endcase
    end

    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar) begin
            mode_q <= ModeClr;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Moore decode of state and opcode; anything not set stays inactive.
    always_comb begin
        ctrl = CtrlIdle;
        unique case (state)
            StClr: ctrl.pc_clr = 1'b1;
            StT1: begin
                ctrl.enable_pc    = 1'b1;
                ctrl.load_mar_bar = 1'b0;
            end
            StT2: ctrl.pc_inc = 1'b1;
            StT3: begin
                ctrl.enable_ram_bar = 1'b0;
                ctrl.ram_read_bar   = 1'b0;
                ctrl.load_ir_bar    = 1'b0;
            end
            StT4: begin
                unique case (opcode)
                    OpLda, OpAdd, OpSub, OpSta: begin
                        ctrl.enable_ir_bar = 1'b0;
                        ctrl.load_mar_bar  = 1'b0;
                    end
                    OpJmp: begin
                        ctrl.enable_ir_bar = 1'b0;
                        ctrl.load_pc       = 1'b1;
                    end
                    OpOut: begin
                        ctrl.enable_a_bar = 1'b0;
                        ctrl.load_out_bar = 1'b0;
                    end
                    OpHlt:   ctrl.halt = 1'b1;
                    default: ;
                endcase
            end
            StT5: begin
                unique case (opcode)
                    OpLda: begin
                        ctrl.ram_read_bar   = 1'b0;
                        ctrl.enable_ram_bar = 1'b0;
                        ctrl.load_a_bar     = 1'b0;
                    end
                    OpAdd, OpSub: begin
                        ctrl.ram_read_bar   = 1'b0;
                        ctrl.enable_ram_bar = 1'b0;
                        ctrl.load_b_bar     = 1'b0;
                    end
                    OpSta: begin
                        ctrl.enable_a_bar  = 1'b0;
                        ctrl.ram_write_bar = 1'b0;
                    end
                    default: ;
                endcase
            end
            StT6: begin
                unique case (opcode)
                    OpAdd: begin
                        ctrl.enable_alu_bar = 1'b0;
                        ctrl.load_a_bar     = 1'b0;
                        ctrl.add_sub_bar    = 1'b1;
                    end
                    OpSub: begin
                        ctrl.enable_alu_bar = 1'b0;
                        ctrl.load_a_bar     = 1'b0;
                        ctrl.add_sub_bar    = 1'b0;
                    end
                    default: ;
                endcase
            end
            StHalt:  ctrl.halt = 1'b1;
            default: ;
        endcase
    end

    assign pc_clr         = ctrl.pc_clr;
    assign pc_inc         = ctrl.pc_inc;
    assign enable_pc      = ctrl.enable_pc;
    assign load_pc        = ctrl.load_pc;
    assign load_mar_bar   = ctrl.load_mar_bar;
    assign ram_read_bar   = ctrl.ram_read_bar;
    assign ram_write_bar  = ctrl.ram_write_bar;
    assign enable_ram_bar = ctrl.enable_ram_bar;
    assign load_ir_bar    = ctrl.load_ir_bar;
    assign enable_ir_bar  = ctrl.enable_ir_bar;
    assign load_a_bar     = ctrl.load_a_bar;
    assign enable_a_bar   = ctrl.enable_a_bar;
    assign load_b_bar     = ctrl.load_b_bar;
    assign add_sub_bar    = ctrl.add_sub_bar;
    assign enable_alu_bar = ctrl.enable_alu_bar;
    assign load_out_bar   = ctrl.load_out_bar;
    assign halt           = ctrl.halt;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small behavioural bus machine (PC, MAR, RAM, IR, A, B,
// ALU, OUT) is driven by the sequencer's strobes and runs a short directed program.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clr_bar = 1'b1;
    logic [3:0] opcode;
    logic       pc_clr, pc_inc, enable_pc, load_pc, load_mar_bar;
    logic       ram_read_bar, ram_write_bar, enable_ram_bar, load_ir_bar, enable_ir_bar;
    logic       load_a_bar, enable_a_bar, load_b_bar, add_sub_bar, enable_alu_bar;
    logic       load_out_bar, halt;
    logic [5:0] t_state;

    always #5 clk = ~clk;

    control_sequencer #(
        .T_STATES(6)
    ) dut (
        .clk           (clk),
        .clr_bar       (clr_bar),
        .opcode        (opcode),
        .pc_clr        (pc_clr),
        .pc_inc        (pc_inc),
        .enable_pc     (enable_pc),
        .load_pc       (load_pc),
        .load_mar_bar  (load_mar_bar),
        .ram_read_bar  (ram_read_bar),
        .ram_write_bar (ram_write_bar),
        .enable_ram_bar(enable_ram_bar),
        .load_ir_bar   (load_ir_bar),
        .enable_ir_bar (enable_ir_bar),
        .load_a_bar    (load_a_bar),
        .enable_a_bar  (enable_a_bar),
        .load_b_bar    (load_b_bar),
        .add_sub_bar   (add_sub_bar),
        .enable_alu_bar(enable_alu_bar),
        .load_out_bar  (load_out_bar),
        .halt          (halt),
        .t_state       (t_state)
    );

    // Observed control word, MSB first in the same order as the masks below.
    logic [16:0] obs;
    assign obs = {pc_clr, pc_inc, enable_pc, load_pc, load_mar_bar, ram_read_bar,
                  ram_write_bar, enable_ram_bar, load_ir_bar, enable_ir_bar, load_a_bar,
                  enable_a_bar, load_b_bar, add_sub_bar, enable_alu_bar, load_out_bar, halt};

    // Each mask flips one strobe from its inactive level to its active level.
    localparam logic [16:0] SPcClr  = 17'h10000;
    localparam logic [16:0] SPcInc  = 17'h08000;
    localparam logic [16:0] SEnPc   = 17'h04000;
    localparam logic [16:0] SLdPc   = 17'h02000;
    localparam logic [16:0] SLdMar  = 17'h01000;
    localparam logic [16:0] SRd     = 17'h00800;
    localparam logic [16:0] SWr     = 17'h00400;
    localparam logic [16:0] SEnRam  = 17'h00200;
    localparam logic [16:0] SLdIr   = 17'h00100;
    localparam logic [16:0] SEnIr   = 17'h00080;
    localparam logic [16:0] SLdA    = 17'h00040;
    localparam logic [16:0] SEnA    = 17'h00020;
    localparam logic [16:0] SLdB    = 17'h00010;
    localparam logic [16:0] SSub    = 17'h00008;
    localparam logic [16:0] SEnAlu  = 17'h00004;
    localparam logic [16:0] SLdOut  = 17'h00002;
    localparam logic [16:0] SHalt   = 17'h00001;
    localparam logic [16:0] IdleWord = 17'h01FFE;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected control word for opcode op in T-state t (1..6), hand-written from the table.
    function automatic logic [16:0] exp_ctrl(input logic [3:0] op, input int t);
        logic [16:0] m;
        m = '0;
        case (t)
            1: m = SEnPc | SLdMar;
            2: m = SPcInc;
            3: m = SEnRam | SRd | SLdIr;
            4: case (op)
                4'h0, 4'h1, 4'h2, 4'h3: m = SEnIr | SLdMar;
                4'h4: m = SEnIr | SLdPc;
                4'hE: m = SEnA | SLdOut;
                4'hF: m = SHalt;
                default: m = '0;
            endcase
            5: case (op)
                4'h0: m = SRd | SEnRam | SLdA;
                4'h1, 4'h2: m = SRd | SEnRam | SLdB;
                4'h3: m = SEnA | SWr;
                default: m = '0;
            endcase
            6: case (op)
                4'h1: m = SEnAlu | SLdA;
                4'h2: m = SEnAlu | SLdA | SSub;
                default: m = '0;
            endcase
            default: m = '0;
        endcase
        return IdleWord ^ m;
    endfunction

    // Behavioural bus machine.
    logic [3:0] pc  = 4'hA;
    logic [3:0] mar = 4'h0;
    logic [7:0] ir  = 8'hF0;  // HLT opcode before the first fetch: must be ignored in T1..T3
    logic [7:0] a_reg = 8'hAA;
    logic [7:0] b_reg = 8'h00;
    logic [7:0] out_reg = 8'h00;
    logic [7:0] ram [16];

    assign opcode = ir[7:4];

    always @(posedge clk) begin
        logic [7:0] bus;
        int drivers;
        drivers = int'(enable_pc) + int'(!enable_ram_bar) + int'(!enable_ir_bar)
                + int'(!enable_a_bar) + int'(!enable_alu_bar);
        check_eq("bus_contention", 32'(drivers > 1), 32'd0);
        bus = 8'h00;
        if (enable_pc)       bus = {4'h0, pc};
        if (!enable_ram_bar) bus = ram[mar];
        if (!enable_ir_bar)  bus = {4'h0, ir[3:0]};
        if (!enable_a_bar)   bus = a_reg;
        if (!enable_alu_bar) bus = add_sub_bar ? a_reg + b_reg : a_reg - b_reg;
        if (pc_clr)           pc <= 4'h0;
        else if (load_pc)     pc <= bus[3:0];
        else if (pc_inc)      pc <= pc + 4'h1;
        if (!load_mar_bar)    mar <= bus[3:0];
        if (!ram_write_bar)   ram[mar] <= bus;
        if (!load_ir_bar)     ir <= bus;
        if (!load_a_bar)      a_reg <= bus;
        if (!load_b_bar)      b_reg <= bus;
        if (!load_out_bar)    out_reg <= bus;
    end

    // Starts at the falling edge inside T1; checks n T-states, ends one state later.
    task automatic run_instr(input string name, input logic [3:0] op, input int n);
        for (int t = 1; t <= n; t++) begin
            check_eq($sformatf("%s_t%0d_state", name, t), 32'(t_state), 32'(1 << (t - 1)));
            check_eq($sformatf("%s_t%0d_ctrl", name, t), 32'(obs), 32'(exp_ctrl(op, t)));
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        ram[0]  = 8'h0D;  // LDA 13
        ram[1]  = 8'h1E;  // ADD 14
        ram[2]  = 8'h3F;  // STA 15
        ram[3]  = 8'h46;  // JMP 6
        ram[4]  = 8'hF0;  // HLT
        ram[6]  = 8'h2E;  // SUB 14
        ram[7]  = 8'h50;  // NOP
        ram[8]  = 8'hE0;  // OUT
        ram[9]  = 8'h44;  // JMP 4
        ram[13] = 8'h1C;
        ram[14] = 8'h05;

        #1 clr_bar = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_ctrl", 32'(obs), 32'(IdleWord ^ SPcClr));
        check_eq("reset_tstate", 32'(t_state), 32'd0);
        clr_bar = 1'b1;
        check_eq("clr_ctrl", 32'(obs), 32'(IdleWord ^ SPcClr));
        @(negedge clk);

        run_instr("lda", 4'h0, 6);
        check_eq("lda_a", 32'(a_reg), 32'h1C);
        check_eq("lda_pc", 32'(pc), 32'd1);
        run_instr("add", 4'h1, 6);
        check_eq("add_a", 32'(a_reg), 32'h21);
        check_eq("add_b", 32'(b_reg), 32'h05);
        run_instr("sta", 4'h3, 6);
        check_eq("sta_ram15", 32'(ram[15]), 32'h21);
        check_eq("sta_pc", 32'(pc), 32'd3);
        run_instr("jmp6", 4'h4, 6);
        check_eq("jmp6_pc", 32'(pc), 32'd6);
        run_instr("sub", 4'h2, 6);
        check_eq("sub_a", 32'(a_reg), 32'h1C);
        run_instr("nop", 4'h5, 6);
        check_eq("nop_a", 32'(a_reg), 32'h1C);
        check_eq("nop_pc", 32'(pc), 32'd8);
        run_instr("out", 4'hE, 6);
        check_eq("out_reg", 32'(out_reg), 32'h1C);
        run_instr("jmp4", 4'h4, 6);
        check_eq("jmp4_pc", 32'(pc), 32'd4);
        run_instr("hlt", 4'hF, 4);
        for (int i = 0; i < 20; i++) begin
            check_eq("halt_ctrl", 32'(obs), 32'(IdleWord ^ SHalt));
            check_eq("halt_tstate", 32'(t_state), 32'd0);
            @(negedge clk);
        end
        check_eq("halt_pc", 32'(pc), 32'd5);

        // Reset out of HALT, then abort an ADD in T5.
        clr_bar = 1'b0;
        #1;
        check_eq("halt_reset_ctrl", 32'(obs), 32'(IdleWord ^ SPcClr));
        @(negedge clk);
        clr_bar = 1'b1;
        @(negedge clk);
        run_instr("lda2", 4'h0, 6);
        check_eq("lda2_a", 32'(a_reg), 32'h1C);
        run_instr("add2", 4'h1, 4);
        check_eq("add2_t5_state", 32'(t_state), 32'b010000);
        clr_bar = 1'b0;
        #1;
        check_eq("abort_ctrl", 32'(obs), 32'(IdleWord ^ SPcClr));
        check_eq("abort_tstate", 32'(t_state), 32'd0);
        @(negedge clk);
        clr_bar = 1'b1;
        check_eq("abort_a", 32'(a_reg), 32'h1C);
        check_eq("abort_b", 32'(b_reg), 32'h05);
        check_eq("abort_clr_ctrl", 32'(obs), 32'(IdleWord ^ SPcClr));
        @(negedge clk);
        check_eq("restart_tstate", 32'(t_state), 32'b000001);
        check_eq("restart_ctrl", 32'(obs), 32'(IdleWord ^ SEnPc ^ SLdMar));
        check_eq("restart_pc", 32'(pc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Control sequencer for the 8-bit bus machine: a ring-counter-driven unit that fetches and executes instructions. It produces every load, enable, clear and increment strobe that the bus modules consume: program counter, memory address register, RAM, instruction register, A/B registers, ALU and output register. It decodes the opcode nibble returned by the instruction register, so no other block has to drive control signals by hand.

## Interface
Parameters:
- T_STATES, 6, number of ring-counter states per instruction; fixed at 6 in this version.

Ports:
- clk  in  1  system clock; all state changes happen on its rising edge
- clr_bar  in  1  asynchronous, active-low reset
- opcode  in  4  upper nibble of the instruction register; valid from T4 onward
- pc_clr  out  1  program counter synchronous clear, active high
- pc_inc  out  1  program counter increment, active high
- enable_pc  out  1  program counter drives the bus, active high
- load_pc  out  1  program counter loads from the bus (jump), active high
- load_mar_bar  out  1  memory address register load, active low
- ram_read_bar  out  1  RAM read, active low
- ram_write_bar  out  1  RAM write, active low
- enable_ram_bar  out  1  RAM drives the bus, active low
- load_ir_bar  out  1  instruction register load, active low
- enable_ir_bar  out  1  instruction register drives its operand nibble onto the bus, active low
- load_a_bar, enable_a_bar  out  1 each  A register load and drive, active low
- load_b_bar  out  1  B register load, active low
- add_sub_bar  out  1  ALU mode: 1 = add, 0 = subtract
- enable_alu_bar  out  1  ALU drives the bus, active low
- load_out_bar  out  1  output register load, active low
- halt  out  1  high once HLT has executed
- t_state  out  6  one-hot ring state, for debug

## Operation
- States: CLR, then T1 through T6, then back to T1. While halted the state is HALT.
- Outputs are a Moore decode of the current state and `opcode`. Any strobe not listed below is at its inactive level.
- CLR: `pc_clr`=1. Next state is T1.
- T1 (address): `enable_pc`=1, `load_mar_bar`=0.
- T2 (increment): `pc_inc`=1.
- T3 (memory): `enable_ram_bar`=0, `ram_read_bar`=0, `load_ir_bar`=0.
- Opcodes: LDA=0000, ADD=0001, SUB=0010, STA=0011, JMP=0100, OUT=1110, HLT=1111. Any other value is a NOP, which runs T4–T6 with no strobes.
- T4:
  - LDA, ADD, SUB, STA: `enable_ir_bar`=0, `load_mar_bar`=0.
  - JMP: `enable_ir_bar`=0, `load_pc`=1.
  - OUT: `enable_a_bar`=0, `load_out_bar`=0.
  - HLT: `halt`=1, and the next state is HALT.
- T5:
  - LDA: RAM read and drive, `load_a_bar`=0.
  - ADD, SUB: RAM read and drive, `load_b_bar`=0.
  - STA: `enable_a_bar`=0, `ram_write_bar`=0.
- T6:
  - ADD: `enable_alu_bar`=0, `load_a_bar`=0, `add_sub_bar`=1.
  - SUB: the same, but `add_sub_bar`=0.
- HALT: all strobes are inactive and `halt`=1. HALT is left only by reset.
- Bus contention rule: at most one bus driver is enabled in any state (`enable_pc`, `enable_ram_bar`, `enable_ir_bar`, `enable_a_bar`, `enable_alu_bar`). This is a bench assertion.

## Timing
- Reset (`clr_bar`=0) is asynchronous. It immediately forces state CLR:
  - `pc_clr`=1, `t_state`=000000, `halt`=0.
  - `add_sub_bar`=1 and every other `_bar` output = 1.
  - `pc_inc`, `enable_pc`, `load_pc` = 0.
- CLR lasts exactly one cycle after `clr_bar` rises. T1 follows on the next rising edge.
- Each state lasts one clock. A strobe takes effect at the rising edge that ends its state.
- Every instruction takes 6 cycles except HLT, which takes 4 cycles and then holds.
- `opcode` is sampled combinationally in T4–T6 only. Changes to `opcode` during T1–T3 have no effect.
- Reset asserted mid-instruction aborts the instruction at once. No partial strobe survives the reset edge.
- `t_state` one-hot bit mapping: bit0 = T1 through bit5 = T6.
- `t_state`=000000 in CLR and in HALT.
- Wrap-around: T6 is followed by T1 with no idle cycle.

## Structure
- Package `ctrl_pkg` holds:
  - the opcode constants (LDA, ADD, SUB, STA, JMP, OUT, HLT);
  - the state encoding (CLR, T1–T6, HALT);
  - the inactive default control word.
- One sub-module, `ring_counter`, generates the one-hot T1–T6 sequence. It has inputs `clk`, `clr_bar`, `run` (low in CLR and HALT).
- The decode is purely combinational in the top module. Its default assignment is the inactive control word.

## Test plan
- Hold `clr_bar`=0 for 2 cycles, then release. Check:
  - all `_bar` outputs = 1 and `pc_clr`=1 during reset;
  - one CLR cycle follows;
  - then T1 shows `enable_pc`=1 and `load_mar_bar`=0.
- RAM[0]=0000_1001 (LDA 9), RAM[9]=8'h1C. After 7 cycles (CLR plus 6): A=8'h1C, PC=1.
- A=8'h1C and ADD 10 with RAM[10]=8'h05: A=8'h21 after T6. Then SUB 10: A=8'h1C, with `add_sub_bar`=0 in T6 only.
- STA 15 with A=8'h21: RAM[15]=8'h21, `ram_write_bar` low only in T5. JMP 3: PC=3 at the next T1.
- HLT at address 4: `halt`=1 at T4 and stays at 1 for 20 cycles, with no strobes active.
- Pulse `clr_bar` low during T5 of an ADD:
  - the outputs go inactive asynchronously;
  - A is unchanged;
  - the sequence restarts from CLR.
